// File: rtl/msi_pkg.sv
// Shared constants, FSM encoding and vector-folding helper for the MSI interrupt arbiter.
package msi_pkg;

  localparam int MSI_MAX_VEC = 32;
  localparam int MSI_VEC_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } msi_state_t;

  // Sources beyond the host allocation all share the top allocated vector.
  function automatic logic [MSI_VEC_W-1:0] fold_vector(input logic [MSI_VEC_W-1:0] src,
                                                       input logic [2:0]           width);
    logic [MSI_VEC_W:0] alloc;
    if (width >= 3'(MSI_VEC_W)) return src;
    alloc = (MSI_VEC_W+1)'(1) << width;
    if ({1'b0, src} < alloc) return src;
    return MSI_VEC_W'(alloc - 1'b1);
  endfunction

endpackage

// File: rtl/msi_irq_arbiter_if.sv
// Endpoint-side MSI port group: request/vector toward the endpoint, grant and config back.
// Handshake: intx_msi_request is held with a stable msi_vector_num until the endpoint returns a
// one-cycle intx_msi_grant; request and vector may only change after that grant (or an enable drop).
interface msi_irq_arbiter_if;
  import msi_pkg::*;

  logic                 intx_msi_request;
  logic [MSI_VEC_W-1:0] msi_vector_num;
  logic                 intx_msi_grant;
  logic                 msi_enable;
  logic [2:0]           msi_vector_width;

  modport master (
    output intx_msi_request,
    output msi_vector_num,
    input  intx_msi_grant,
    input  msi_enable,
    input  msi_vector_width
  );

  modport slave (
    input  intx_msi_request,
    input  msi_vector_num,
    output intx_msi_grant,
    output msi_enable,
    output msi_vector_width
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: first set req bit searching upward from last+1,
// wrapping modulo N.
module rr_pick
  import msi_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]           req,
  input  logic [MSI_VEC_W-1:0]   last,
  output logic                   valid,
  output logic [MSI_VEC_W-1:0]   idx
);

  int pos;

  // Scan from the farthest offset down so the nearest hit after 'last' is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = N; k >= 1; k--) begin
      pos = (int'(last) + k) % N;
      if (req[pos]) begin
        valid = 1'b1;
        idx   = MSI_VEC_W'(pos);
      end
    end
  end

endmodule

// File: rtl/msi_irq_arbiter.sv
// Edge-captures up to 32 interrupt sources, arbitrates pending ones round-robin and issues
// one MSI request at a time toward the PCIe endpoint, counting events merged into pending ones.
module msi_irq_arbiter
  import msi_pkg::*;
#(
  parameter int NUM_IRQ   = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_IRQ-1:0]   irq_in,
  input  logic [NUM_IRQ-1:0]   irq_mask,
  output logic [NUM_IRQ-1:0]   irq_pending,
  output logic [CNT_WIDTH-1:0] irq_coalesce_cnt,
  output msi_state_t           state_dbg,
  msi_irq_arbiter_if.master    ep
);

  localparam int                   SUM_W   = CNT_WIDTH + 6;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  msi_state_t            state_q, state_d;
  logic [NUM_IRQ-1:0]    irq_q, rise, eligible, grant_clr, pending_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]      sum;
  logic [5:0]            hit_cnt;
  logic [MSI_VEC_W-1:0]  src_q, vec_q, last_q, pick_idx;
  logic                  pick_valid, launch, grant_fire;

  // Edge history runs through reset so a source held high at release is not an event.
  always_ff @(posedge clk) begin
    irq_q <= irq_in;
  end

  assign rise     = irq_in & ~irq_q;
  assign eligible = pending_q & ~irq_mask;

  rr_pick #(.N(NUM_IRQ)) u_pick (
    .req   (eligible),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign launch     = (state_q == ST_IDLE) && ep.msi_enable && pick_valid;
  assign grant_fire = (state_q == ST_REQ) && ep.intx_msi_grant;

  always_comb begin
    grant_clr = '0;
    hit_cnt   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      grant_clr[i] = grant_fire && (src_q == MSI_VEC_W'(i));
      hit_cnt      = hit_cnt + 6'(rise[i] & pending_q[i]);
    end
    sum   = SUM_W'(cnt_q) + SUM_W'(hit_cnt);
    cnt_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; a grant wins over a simultaneous enable drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_REQ;
      ST_REQ: begin
        if (ep.intx_msi_grant)   state_d = ST_GAP;
        else if (!ep.msi_enable) state_d = ST_IDLE;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ep.intx_msi_request = 1'b0;
    ep.msi_vector_num   = '0;
    if (state_q == ST_REQ) begin
      ep.intx_msi_request = 1'b1;
      ep.msi_vector_num   = vec_q;
    end
  end

  // Pending set has priority over a same-cycle grant clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      src_q     <= '0;
      vec_q     <= '0;
      last_q    <= MSI_VEC_W'(NUM_IRQ - 1);
    end else begin
      pending_q <= (pending_q & ~grant_clr) | rise;
      cnt_q     <= cnt_d;
      if (launch) begin
        src_q <= pick_idx;
        vec_q <= fold_vector(pick_idx, ep.msi_vector_width);
      end
      if (grant_fire) last_q <= src_q;
    end
  end

  assign irq_pending      = pending_q;
  assign irq_coalesce_cnt = cnt_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_msi_irq_arbiter.sv
// Bench for msi_irq_arbiter: directed scenarios plus random traffic against a cycle-level
// reference model; a narrow-counter twin instance exercises counter saturation.
module tb_msi_irq_arbiter;
  import msi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic [31:0] irq, mask;
  logic        en, grant;
  logic [2:0]  vw;

  msi_irq_arbiter_if ep();
  msi_irq_arbiter_if ep_s();

  assign ep.intx_msi_grant     = grant;
  assign ep.msi_enable         = en;
  assign ep.msi_vector_width   = vw;
  assign ep_s.intx_msi_grant   = grant;
  assign ep_s.msi_enable       = en;
  assign ep_s.msi_vector_width = vw;

  logic [31:0] pend_w, pend_s;
  logic [15:0] cnt_w;
  logic [2:0]  cnt_s;
  msi_state_t  state_w, state_s;

  msi_irq_arbiter #(.NUM_IRQ(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq), .irq_mask(mask),
    .irq_pending(pend_w), .irq_coalesce_cnt(cnt_w), .state_dbg(state_w), .ep(ep)
  );

  msi_irq_arbiter #(.NUM_IRQ(32), .CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .irq_in(irq), .irq_mask(mask),
    .irq_pending(pend_s), .irq_coalesce_cnt(cnt_s), .state_dbg(state_s), .ep(ep_s)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit [31:0] m_pend, m_prev;
  bit        m_req, m_gap;
  int        m_src, m_vec, m_last, m_cnt;

  function automatic int exp_vec(input int src, input int width);
    int w, alloc;
    w     = (width > 5) ? 5 : width;
    alloc = 1 << w;
    return (src < alloc) ? src : alloc - 1;
  endfunction

  task automatic model_step();
    int  old_src, win, hits, p;
    bit  granted, r;
    if (!rst_n) begin
      m_pend = '0; m_cnt = 0; m_req = 0; m_gap = 0;
      m_last = 31; m_src = 0; m_vec = 0; m_prev = irq;
      return;
    end
    old_src = m_src;
    granted = m_req && grant;
    if (m_req) begin
      if (granted) begin m_req = 0; m_gap = 1; m_last = m_src; end
      else if (!en) m_req = 0;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (en) begin
      win = -1;
      for (int k = 1; k <= 32; k++) begin
        p = (m_last + k) % 32;
        if (win < 0 && m_pend[p] && !mask[p]) win = p;
      end
      if (win >= 0) begin m_req = 1; m_src = win; m_vec = exp_vec(win, int'(vw)); end
    end
    hits = 0;
    for (int i = 0; i < 32; i++) begin
      r = irq[i] && !m_prev[i];
      if (r && m_pend[i]) hits++;
      m_pend[i] = r || (m_pend[i] && !(granted && i == old_src));
    end
    m_cnt  = (m_cnt + hits > 65535) ? 65535 : m_cnt + hits;
    m_prev = irq;
  endtask

  task automatic compare_all();
    check("req",      ep.intx_msi_request, m_req);
    check("vec",      ep.msi_vector_num, m_req ? m_vec : 0);
    check("pend",     pend_w, m_pend);
    check("cnt",      cnt_w, m_cnt);
    check("cnt_sat",  cnt_s, (m_cnt > 7) ? 7 : m_cnt);
    check("dbg_idle", state_w == ST_IDLE, !m_req && !m_gap);
  endtask

  // ---------------- scoreboard of granted vectors ----------------
  logic [31:0] exp_q[$];
  bit          sb_on;

  // ---------------- driver tasks ----------------
  task automatic tick();
    bit          acc;
    logic [31:0] acc_vec;
    acc     = sb_on && rst_n && grant && ep.intx_msi_request;
    acc_vec = ep.msi_vector_num;
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    if (acc) begin
      if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
      else                   check("sb_vec", acc_vec, exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    check("sb_drain", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b0; grant = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse(input logic [31:0] bits);
    irq = irq | bits;
    tick();
    irq = irq & ~bits;
  endtask

  task automatic serve(input int budget);
    int n = 0;
    while (!ep.intx_msi_request && n < budget) begin
      tick();
      n++;
    end
    check("serve_timeout", ep.intx_msi_request, 1);
    if (ep.intx_msi_request) begin
      grant = 1'b1;
      tick();
      grant = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    irq = '0; mask = '0; en = 1'b1; grant = 1'b0; vw = 3'd5; rst_n = 1'b0; sb_on = 1'b1;
    tick();
    check("rst_req", ep.intx_msi_request, 0);
    check("rst_cnt", cnt_w, 0);

    // single event on source 7, grant three cycles after request
    do_reset();
    irq[7] = 1'b1; tick();
    check("t1_pend", pend_w[7], 1);
    check("t1_req_early", ep.intx_msi_request, 0);
    irq[7] = 1'b0; tick();
    check("t1_req", ep.intx_msi_request, 1);
    check("t1_vec", ep.msi_vector_num, 7);
    exp_q.push_back(7);
    repeat (3) tick();
    grant = 1'b1; tick(); grant = 1'b0;
    check("t1_req_fall", ep.intx_msi_request, 0);
    check("t1_pend_clr", pend_w[7], 0);
    repeat (3) tick();

    // folding with 4 allocated vectors
    do_reset();
    vw = 3'd2;
    exp_q.push_back(2); exp_q.push_back(3);
    pulse(32'h0000_0204);
    tick();
    check("fold_vec_a", ep.msi_vector_num, 2);
    grant = 1'b1; tick(); grant = 1'b0;
    tick(); tick();
    check("fold_req_b", ep.intx_msi_request, 1);
    check("fold_vec_b", ep.msi_vector_num, 3);
    serve(4);
    repeat (3) tick();

    // round-robin order, then coalescing on source 5
    do_reset();
    vw = 3'd5;
    exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(31);
    pulse(32'h8000_0021);
    repeat (3) serve(8);
    repeat (3) tick();
    check("rr_done", exp_q.size(), 0);
    en = 1'b0;
    pulse(32'h20); tick(); pulse(32'h20); tick();
    check("coal_cnt", cnt_w, 1);
    en = 1'b1;
    exp_q.push_back(5);
    serve(8);
    repeat (4) tick();
    check("coal_single", ep.intx_msi_request, 0);

    // enable and mask control
    do_reset();
    en = 1'b0;
    pulse(32'h8);
    repeat (3) tick();
    check("en_off_req", ep.intx_msi_request, 0);
    check("en_off_pend", pend_w[3], 1);
    en = 1'b1; tick();
    check("en_on_vec", ep.msi_vector_num, 3);
    en = 1'b0; tick();
    check("en_drop_req", ep.intx_msi_request, 0);
    check("en_drop_pend", pend_w[3], 1);
    en = 1'b1;
    exp_q.push_back(3);
    serve(8);
    mask[4] = 1'b1;
    pulse(32'h10);
    repeat (4) tick();
    check("mask_req", ep.intx_msi_request, 0);
    check("mask_pend", pend_w[4], 1);
    mask[4] = 1'b0;
    exp_q.push_back(4);
    serve(8);
    tick();

    // source held high through reset
    irq[0] = 1'b1;
    do_reset();
    repeat (3) tick();
    check("hold_pend0", pend_w[0], 0);
    irq[0] = 1'b0;
    tick();

    // rise on the same cycle as its own grant
    do_reset();
    exp_q.push_back(6); exp_q.push_back(6);
    pulse(32'h40);
    tick();
    irq[6] = 1'b1; grant = 1'b1; tick(); grant = 1'b0; irq[6] = 1'b0;
    check("same_pend6", pend_w[6], 1);
    serve(8);
    tick();
    check("same_clr6", pend_w[6], 0);

    // reset in the middle of a request
    do_reset();
    pulse(32'h2);
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("mid_rst_req", ep.intx_msi_request, 0);
    check("mid_rst_pend", pend_w, 0);

    // counter saturation on the narrow twin
    do_reset();
    en = 1'b0;
    repeat (9) begin pulse(32'h20); tick(); end
    check("sat_wide", cnt_w, 8);
    check("sat_narrow", cnt_s, 7);
    en = 1'b1;
    exp_q.push_back(5);
    serve(8);
    do_reset();

    // randomized traffic against the model
    sb_on = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      irq   = $urandom & $urandom & $urandom;
      grant = ($urandom_range(0, 9) < 4);
      en    = ($urandom_range(0, 19) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 49) == 0) mask = $urandom & $urandom;
      if ($urandom_range(0, 99) == 0) vw = 3'($urandom_range(0, 7));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
